or8_way: RTL and testbench



---
 rtl/or8_way_pkg.sv | 20 ++
 rtl/or8_way_if.sv | 35 +++
 rtl/or8_way_popcnt.sv | 24 ++
 rtl/or8_way.sv | 101 ++++++++++
 tb/tb_or8_way.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/or8_way_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : or8_way_pkg
//  Purpose  : Shared widths and types for the 8-input OR reduction block.
//  Contents : OR8_W / OR8_IDX_W / OR8_CNT_W constants and the data, index
//             and count typedefs used by or8_way and its sub-module.
//  Revision : 1.0  initial release
// ============================================================================
package or8_way_pkg;

    localparam int OR8_W     = 8;
    localparam int OR8_IDX_W = 3;
    localparam int OR8_CNT_W = 4;

    typedef logic [OR8_W-1:0]     or8_data_t;
    typedef logic [OR8_IDX_W-1:0] or8_idx_t;
    typedef logic [OR8_CNT_W-1:0] or8_cnt_t;

endpackage
`default_nettype wire

// File: rtl/or8_way_if.sv
`default_nettype none
// ============================================================================
//  Module   : or8_way_if
//  Purpose  : Bundles the data-side signals of or8_way so that producers and
//             consumers can pass them around as one object.
//  Signals  : in, clr           - driven by the master
//             out               - combinational OR result
//             out_q, idx_q,
//             cnt_q, sticky_q   - registered results
//  Modports : master (drives in/clr), slave (the or8_way side)
//  Revision : 1.0  initial release
// ============================================================================
interface or8_way_if;
    import or8_way_pkg::*;

    or8_data_t in;
    logic      clr;
    logic      out;
    logic      out_q;
    or8_idx_t  idx_q;
    or8_cnt_t  cnt_q;
    logic      sticky_q;

    modport master (
        output in, clr,
        input  out, out_q, idx_q, cnt_q, sticky_q
    );

    modport slave (
        input  in, clr,
        output out, out_q, idx_q, cnt_q, sticky_q
    );

endinterface
`default_nettype wire

// File: rtl/or8_way_popcnt.sv
`default_nettype none
// ============================================================================
//  Module   : or8_way_popcnt
//  Purpose  : Combinational population count of an 8-bit word.
//  Ports    : data (in, 8)  - word to count
//             cnt  (out, 4) - number of set bits, 0..8
//  Revision : 1.0  initial release
// ============================================================================
module or8_way_popcnt
    import or8_way_pkg::*;
(
    input  wire or8_data_t data,
    output or8_cnt_t       cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < OR8_W; i++) begin
            cnt = cnt + or8_cnt_t'(data[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/or8_way.sv
`default_nettype none
// ============================================================================
//  Module   : or8_way
//  Purpose  : 8-input OR reduction. 'out' is purely combinational; the _q
//             outputs present the OR, lowest-set-bit index and popcount of
//             'in' one clock later.
//  Ports    : in       (in, 8)  data to reduce
//             out      (out,1)  combinational OR of in
//             clk      (in, 1)  clock for the registered outputs
//             rst_n    (in, 1)  asynchronous active-low reset
//             clr      (in, 1)  synchronous clear of sticky_q
//             out_q    (out,1)  registered OR
//             idx_q    (out,3)  registered index of lowest set bit (0 if none)
//             cnt_q    (out,4)  registered popcount
//             sticky_q (out,1)  "any bit ever set" flag
//  Config   : OR8_WAY_STICKY_EN enables the sticky flag and clr; otherwise
//             sticky_q is constant 0 and clr is ignored.
//  Note     : in/out come first so a positional (in, out) instance works.
//  Revision : 1.0  initial release
// ============================================================================
module or8_way
    import or8_way_pkg::*;
(
    input  wire or8_data_t in,
    output logic           out,
    input  wire            clk,
    input  wire            rst_n,
    input  wire            clr,
    output logic           out_q,
    output or8_idx_t       idx_q,
    output or8_cnt_t       cnt_q,
    output logic           sticky_q
);

    logic     w_or;
    or8_idx_t w_idx;
    or8_cnt_t w_cnt;

    logic     r_out_q;
    or8_idx_t r_idx_q;
    or8_cnt_t r_cnt_q;

    // Reduction OR keeps normal X/Z propagation; no register in this path.
    assign w_or = |in;
    assign out  = w_or;

    // Priority encoder: scanning from the top down lets bit 0 win last.
    always_comb begin
        w_idx = '0;
        for (int i = OR8_W - 1; i >= 0; i--) begin
            if (in[i]) begin
                w_idx = or8_idx_t'(i);
            end
        end
    end

    or8_way_popcnt u_popcnt (
        .data (in),
        .cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= 1'b0;
            r_idx_q <= '0;
            r_cnt_q <= '0;
        end else begin
            r_out_q <= w_or;
            r_idx_q <= w_idx;
            r_cnt_q <= w_cnt;
        end
    end

    assign out_q = r_out_q;
    assign idx_q = r_idx_q;
    assign cnt_q = r_cnt_q;

`ifdef OR8_WAY_STICKY_EN
    logic r_sticky_q;

    // Clear takes priority over a set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_q <= 1'b0;
        end else if (clr) begin
            r_sticky_q <= 1'b0;
        end else if (w_or) begin
            r_sticky_q <= 1'b1;
        end
    end

    assign sticky_q = r_sticky_q;
`else
    // Feature disabled: no sticky register, clr deliberately left unused.
    logic w_unused_clr;
    assign w_unused_clr = clr;
    assign sticky_q     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_or8_way.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or8_way
//  Purpose  : Self-checking bench for or8_way. Stimulus pushes hand-computed
//             expected registered results into a scoreboard queue; a monitor
//             pops and compares them after the capturing clock edge.
//  Config   : honours OR8_WAY_STICKY_EN to pick the expected sticky values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_or8_way;
    import or8_way_pkg::*;

`ifdef OR8_WAY_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct {
        int        due;
        logic      out_q;
        or8_idx_t  idx_q;
        or8_cnt_t  cnt_q;
        logic      sticky_q;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    or8_way_if bus();

    or8_way dut (
        .in       (bus.in),
        .out      (bus.out),
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .out_q    (bus.out_q),
        .idx_q    (bus.idx_q),
        .cnt_q    (bus.cnt_q),
        .sticky_q (bus.sticky_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs are valid every cycle; compare the entry
    // whose capture edge has just happened.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL stale_entry actual=%0d required=%0d", cyc, e.due);
                end else begin
                    chk("out_q",    32'(bus.out_q),    32'(e.out_q));
                    chk("idx_q",    32'(bus.idx_q),    32'(e.idx_q));
                    chk("cnt_q",    32'(bus.cnt_q),    32'(e.cnt_q));
                    chk("sticky_q", 32'(bus.sticky_q), 32'(e.sticky_q));
                end
            end
        end
    end

    // Apply one input word between edges and queue what the next edge must
    // capture; the combinational output is checked straight away.
    task automatic drive(input or8_data_t v, input logic c, input logic eo,
                         input or8_idx_t ei, input or8_cnt_t ec, input logic es);
        exp_t e;
        @(negedge clk);
        bus.in  = v;
        bus.clr = c;
        e.due      = cyc + 1;
        e.out_q    = eo;
        e.idx_q    = ei;
        e.cnt_q    = ec;
        e.sticky_q = es;
        sb.push_back(e);
        #1;
        chk("out_comb", 32'(bus.out), 32'(eo));
    endtask

    typedef struct {
        or8_data_t v;
        logic      o;
        or8_idx_t  i;
        or8_cnt_t  c;
    } vec_t;

    vec_t vecs[7];
    or8_data_t comb_in[5];
    logic      comb_out[5];
    logic      stk_clr[6];
    or8_data_t stk_in[6];
    logic      stk_exp[6];

    initial begin
        cyc     = 0;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.in  = 8'h00;
        bus.clr = 1'b0;

        vecs[0] = '{8'h00, 1'b0, 3'd0, 4'd0};
        vecs[1] = '{8'h01, 1'b1, 3'd0, 4'd1};
        vecs[2] = '{8'h10, 1'b1, 3'd4, 4'd1};
        vecs[3] = '{8'hFF, 1'b1, 3'd0, 4'd8};
        vecs[4] = '{8'h55, 1'b1, 3'd0, 4'd4};
        vecs[5] = '{8'h80, 1'b1, 3'd7, 4'd1};
        vecs[6] = '{8'h03, 1'b1, 3'd0, 4'd2};

        comb_in  = '{8'h00, 8'h01, 8'h10, 8'hFF, 8'h55};
        comb_out = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        stk_clr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        stk_in  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
        stk_exp = '{1'b0, 1'b0, STK, STK, 1'b0, STK};

        // Reset state, and the combinational path while held in reset.
        #2;
        chk("rst_out_q",    32'(bus.out_q),    32'd0);
        chk("rst_idx_q",    32'(bus.idx_q),    32'd0);
        chk("rst_cnt_q",    32'(bus.cnt_q),    32'd0);
        chk("rst_sticky_q", 32'(bus.sticky_q), 32'd0);
        for (int k = 0; k < 5; k++) begin
            bus.in = comb_in[k];
            #1;
            chk("comb_out", 32'(bus.out), 32'(comb_out[k]));
            #9;
        end
        bus.in = 8'h00;

        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Sticky sequence: set, hold, clear-over-set, set again.
        for (int k = 0; k < 6; k++) begin
            drive(stk_in[k], stk_clr[k], |stk_in[k],
                  (stk_in[k] == 8'h01 || stk_in[k] == 8'hFF || stk_in[k] == 8'h00) ? 3'd0 : 3'd0,
                  (stk_in[k] == 8'hFF) ? 4'd8 : (stk_in[k] == 8'h01) ? 4'd1 : 4'd0,
                  stk_exp[k]);
        end

        // Directed table, one word per cycle; sticky stays set.
        for (int k = 0; k < 7; k++) begin
            drive(vecs[k].v, 1'b0, vecs[k].o, vecs[k].i, vecs[k].c, STK);
        end

        // Mid-stream reset with in=FF.
        for (int k = 0; k < 3; k++) begin
            drive(8'hFF, 1'b0, 1'b1, 3'd0, 4'd8, STK);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_out_q",    32'(bus.out_q),    32'd0);
        chk("mid_rst_idx_q",    32'(bus.idx_q),    32'd0);
        chk("mid_rst_cnt_q",    32'(bus.cnt_q),    32'd0);
        chk("mid_rst_sticky_q", 32'(bus.sticky_q), 32'd0);
        chk("mid_rst_out",      32'(bus.out),      32'd1);
        @(negedge clk);
        #1;
        chk("held_rst_cnt_q", 32'(bus.cnt_q), 32'd0);
        chk("held_rst_out",   32'(bus.out),   32'd1);
        begin
            exp_t e;
            e.due      = cyc + 1;
            e.out_q    = 1'b1;
            e.idx_q    = 3'd0;
            e.cnt_q    = 4'd8;
            e.sticky_q = STK;
            rst_n = 1'b1;
            sb.push_back(e);
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 4 && sb.size() > 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
